// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: machine word and RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/memarb_pkg.sv
// Types shared by the memory arbiter and its round-robin helper.
package memarb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DSERVE = 2'd1, ISERVE = 2'd2} arb_state_t;
    typedef enum logic {DATA = 1'b0, INSTR = 1'b1} req_class_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Serializes per-core icache/dcache requests onto one RAM port; dcache wins,
// round-robin within a class, and a dcache owner keeps the port for a block.
module memory_arbiter
    import cpu_types_pkg::*;
    import memarb_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic      [CPUS-1:0]   iREN,
    input  word_t     [CPUS-1:0]   iaddr,
    output logic      [CPUS-1:0]   iwait,
    output word_t     [CPUS-1:0]   iload,
    input  logic      [CPUS-1:0]   dREN,
    input  logic      [CPUS-1:0]   dWEN,
    input  word_t     [CPUS-1:0]   daddr,
    input  word_t     [CPUS-1:0]   dstore,
    output logic      [CPUS-1:0]   dwait,
    output word_t     [CPUS-1:0]   dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output word_t                  ramaddr,
    output word_t                  ramstore,
    input  word_t                  ramload,
    input  ramstate_t              ramstate
);
    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int BW = $clog2(BLOCK_WORDS) + 1;

    arb_state_t  state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, rr_after;
    logic [BW-1:0] beat_q, beat_d, beat_inc;
    logic [CPUS-1:0] d_grant, i_grant;
    logic            d_valid, i_valid;
    logic [OW-1:0]   d_idx, i_idx;
    req_class_t      win_class;

    rr_arbiter #(.N(CPUS), .PW(OW)) u_data_arb (
        .req(dREN | dWEN), .ptr(rr_q), .grant(d_grant), .valid(d_valid)
    );
    rr_arbiter #(.N(CPUS), .PW(OW)) u_instr_arb (
        .req(iREN), .ptr(rr_q), .grant(i_grant), .valid(i_valid)
    );

    always_comb begin
        d_idx = '0;
        i_idx = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (d_grant[c]) d_idx = OW'(c);
            if (i_grant[c]) i_idx = OW'(c);
        end
    end

    // Read data is broadcast; consumers qualify it with their own wait.
    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

    assign win_class = d_valid ? DATA : INSTR;
    assign rr_after  = (owner_q == OW'(CPUS - 1)) ? '0 : owner_q + OW'(1);
    assign beat_inc  = beat_q + BW'(1);

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (d_valid || i_valid) begin
                    state_d = (win_class == DATA) ? DSERVE : ISERVE;
                    owner_d = (win_class == DATA) ? d_idx : i_idx;
                    beat_d  = '0;
                end
            end
            DSERVE: begin
                if (dWEN[owner_q] || dREN[owner_q]) begin
                    ramaddr = daddr[owner_q];
                    if (dWEN[owner_q]) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore[owner_q];
                    end else begin
                        ramREN = 1'b1;
                    end
                    // BUSY/FREE/ERROR all hold the strobes until the RAM reports ACCESS.
                    if (ramstate == ACCESS) begin
                        dwait[owner_q] = 1'b0;
                        beat_d         = beat_inc;
                        if (beat_inc == BW'(BLOCK_WORDS)) begin
                            state_d = IDLE;
                            rr_d    = rr_after;
                        end
                    end
                end else begin
                    state_d = IDLE;
                    rr_d    = rr_after;
                end
            end
            ISERVE: begin
                if (iREN[owner_q]) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[owner_q];
                    if (ramstate == ACCESS) begin
                        iwait[owner_q] = 1'b0;
                        state_d        = IDLE;
                        rr_d           = rr_after;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS        = 2;
    localparam int BLOCK_WORDS = 2;

    logic                CLK, RST;
    logic  [CPUS-1:0]    iREN, iwait, dREN, dWEN, dwait;
    word_t [CPUS-1:0]    iaddr, iload, daddr, dstore, dload;
    logic                ramREN, ramWEN;
    word_t               ramaddr, ramstore, ramload;
    ramstate_t           ramstate;

    int checks = 0;
    int errors = 0;

    memory_arbiter #(.CPUS(CPUS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        dREN = 2'b11; iREN = 2'b11; dWEN = 2'b01; ramstate = ACCESS;
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN got %b want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN got %b want 0", ramWEN); end
        checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait got %b want 11", dwait); end
        checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait got %b want 11", iwait); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
        @(negedge CLK);
        RST = 1'b0;
        clear_inputs();
    endtask

    task automatic test_block_read();
        @(negedge CLK);
        dREN = 2'b01; daddr[0] = 32'h40; iREN = 2'b10; iaddr[1] = 32'h300;
        ramstate = ACCESS; ramload = 32'hAAAA0001;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL blk_arb ramREN=%b dwait=%b want 0/11", ramREN, dwait); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL blk_beat0_ram ren=%b addr=%h want 1/40", ramREN, ramaddr); end
        checks++; if (dwait !== 2'b10 || iwait !== 2'b11) begin errors++; $display("FAIL blk_beat0_wait dwait=%b iwait=%b want 10/11", dwait, iwait); end
        checks++; if (dload[0] !== 32'hAAAA0001) begin errors++; $display("FAIL blk_beat0_data got %h want AAAA0001", dload[0]); end
        @(negedge CLK);
        daddr[0] = 32'h44; ramload = 32'hAAAA0002;
        #1;
        checks++; if (ramaddr !== 32'h44 || dwait !== 2'b10 || iwait !== 2'b11) begin errors++; $display("FAIL blk_beat1 addr=%h dwait=%b iwait=%b want 44/10/11", ramaddr, dwait, iwait); end
        checks++; if (dload[0] !== 32'hAAAA0002) begin errors++; $display("FAIL blk_beat1_data got %h want AAAA0002", dload[0]); end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL blk_idle ramREN=%b iwait=%b want 0/11", ramREN, iwait); end
        @(negedge CLK);
        ramload = 32'h12345678;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || iwait !== 2'b01) begin errors++; $display("FAIL blk_iserve ren=%b addr=%h iwait=%b want 1/300/01", ramREN, ramaddr, iwait); end
        checks++; if (iload[1] !== 32'h12345678) begin errors++; $display("FAIL blk_iload got %h want 12345678", iload[1]); end
        @(negedge CLK);
        iREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL blk_end ren=%b iwait=%b want 0/11", ramREN, iwait); end
    endtask

    task automatic test_priority();
        @(negedge CLK);
        iREN = 2'b01; iaddr[0] = 32'h100;
        dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hDEADBEEF; ramstate = FREE;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL pri_arb wen=%b ren=%b want 0/0", ramWEN, ramREN); end
        @(negedge CLK); #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200) begin errors++; $display("FAIL pri_write wen=%b ren=%b addr=%h want 1/0/200", ramWEN, ramREN, ramaddr); end
        checks++; if (ramstore !== 32'hDEADBEEF || dwait !== 2'b11 || iwait !== 2'b11) begin errors++; $display("FAIL pri_store st=%h dwait=%b iwait=%b want DEADBEEF/11/11", ramstore, dwait, iwait); end
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        checks++; if (dwait !== 2'b01 || ramWEN !== 1'b1 || iwait !== 2'b11) begin errors++; $display("FAIL pri_done dwait=%b wen=%b iwait=%b want 01/1/11", dwait, ramWEN, iwait); end
        @(negedge CLK);
        dWEN = 2'b00;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dwait !== 2'b11) begin errors++; $display("FAIL pri_drop wen=%b st=%h dwait=%b want 0/0/11", ramWEN, ramstore, dwait); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL pri_iarb ren=%b iwait=%b want 0/11", ramREN, iwait); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 2'b10) begin errors++; $display("FAIL pri_iserve ren=%b addr=%h iwait=%b want 1/100/10", ramREN, ramaddr, iwait); end
        @(negedge CLK);
        iREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL pri_end ren=%b want 0", ramREN); end
    endtask

    task automatic test_fairness();
        int core;
        @(negedge CLK);
        dREN = 2'b11; daddr[0] = 32'h1000; daddr[1] = 32'h2000; ramstate = ACCESS;
        // previous instruction owner was core 0, so core 1 is next in line
        for (int blk = 0; blk < 4; blk++) begin
            core = (1 + blk) % CPUS;
            if (blk != 0) @(negedge CLK);
            #1;
            checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL fair_arb%0d ren=%b dwait=%b want 0/11", blk, ramREN, dwait); end
            for (int b = 0; b < BLOCK_WORDS; b++) begin
                @(negedge CLK); #1;
                checks++;
                if (ramREN !== 1'b1 || ramaddr !== (core == 1 ? 32'h2000 : 32'h1000) || dwait !== ~(2'b01 << core)) begin
                    errors++; $display("FAIL fair_blk%0d_beat%0d ren=%b addr=%h dwait=%b want core %0d", blk, b, ramREN, ramaddr, dwait, core);
                end
            end
        end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL fair_end ren=%b dwait=%b want 0/11", ramREN, dwait); end
    endtask

    task automatic test_busy();
        @(negedge CLK);
        dREN = 2'b01; daddr[0] = 32'h8; ramstate = BUSY;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL busy_arb ren=%b want 0", ramREN); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            ramstate = (i == 3) ? ERROR : BUSY;
            #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h8 || dwait !== 2'b11) begin errors++; $display("FAIL busy_hold%0d ren=%b addr=%h dwait=%b want 1/8/11", i, ramREN, ramaddr, dwait); end
        end
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        checks++; if (ramREN !== 1'b1 || dwait !== 2'b10) begin errors++; $display("FAIL busy_done ren=%b dwait=%b want 1/10", ramREN, dwait); end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL busy_drop ren=%b dwait=%b want 0/11", ramREN, dwait); end
    endtask

    task automatic test_drop();
        @(negedge CLK);
        dREN = 2'b10; daddr[1] = 32'h10; ramstate = ACCESS;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_arb ren=%b want 0", ramREN); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || dwait !== 2'b01) begin errors++; $display("FAIL drop_beat ren=%b dwait=%b want 1/01", ramREN, dwait); end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL drop_release ren=%b dwait=%b want 0/11", ramREN, dwait); end
        @(negedge CLK);
        dREN = 2'b11; daddr[0] = 32'h30;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_rearb ren=%b want 0", ramREN); end
        @(negedge CLK); #1;
        checks++; if (ramaddr !== 32'h30 || dwait !== 2'b10) begin errors++; $display("FAIL drop_rr addr=%h dwait=%b want 30/10", ramaddr, dwait); end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_end ren=%b want 0", ramREN); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge CLK);
        dREN = 2'b10; daddr[1] = 32'h20; ramstate = ACCESS;
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || dwait !== 2'b01) begin errors++; $display("FAIL rstb_beat0 ren=%b dwait=%b want 1/01", ramREN, dwait); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rstb_pre ren=%b want 1", ramREN); end
        #2 RST = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11 || iwait !== 2'b11) begin errors++; $display("FAIL rstb_async ren=%b wen=%b dwait=%b iwait=%b want 0/0/11/11", ramREN, ramWEN, dwait, iwait); end
        @(negedge CLK);
        dREN = 2'b11; daddr[0] = 32'h50;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL rstb_held ren=%b dwait=%b want 0/11", ramREN, dwait); end
        RST = 1'b0;
        @(negedge CLK); #1;
        checks++; if (ramaddr !== 32'h50 || dwait !== 2'b10) begin errors++; $display("FAIL rstb_core0 addr=%h dwait=%b want 50/10", ramaddr, dwait); end
        @(negedge CLK);
        dREN = 2'b00;
    endtask

    task automatic test_random();
        int busy, isdata, core, beats, rrm, found, c;
        logic [CPUS-1:0] ew_i, ew_d, idone;
        logic er, ew;
        word_t ea, es;
        int r;
        @(negedge CLK);
        clear_inputs();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        busy = 0; isdata = 0; core = 0; beats = 0; rrm = 0;
        idone = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            for (int k = 0; k < CPUS; k++) begin
                if (idone[k]) iREN[k] = 1'b0;
                else if (!iREN[k] && $urandom_range(0, 3) == 0) iREN[k] = 1'b1;
                if ($urandom_range(0, 3) == 0) dREN[k] = ~dREN[k];
                if ($urandom_range(0, 7) == 0) dWEN[k] = ~dWEN[k];
                iaddr[k] = $urandom; daddr[k] = $urandom; dstore[k] = $urandom;
            end
            ramload = $urandom;
            r = $urandom_range(0, 7);
            ramstate = (r < 4) ? ACCESS : (r < 6) ? BUSY : (r == 6) ? FREE : ERROR;
            #1;
            // reference: one transaction in flight; expected port activity from its owner
            er = 1'b0; ew = 1'b0; ea = '0; es = '0; ew_i = '1; ew_d = '1;
            if (busy == 0) begin
                found = 0;
                for (int k = 0; k < CPUS; k++) begin
                    c = (rrm + k) % CPUS;
                    if (found == 0 && (dREN[c] || dWEN[c])) begin found = 1; isdata = 1; core = c; end
                end
                for (int k = 0; k < CPUS; k++) begin
                    c = (rrm + k) % CPUS;
                    if (found == 0 && iREN[c]) begin found = 1; isdata = 0; core = c; end
                end
                if (found != 0) begin busy = 1; beats = 0; end
            end else if (isdata != 0) begin
                if (dWEN[core]) begin ew = 1'b1; ea = daddr[core]; es = dstore[core]; end
                else if (dREN[core]) begin er = 1'b1; ea = daddr[core]; end
                if (!dWEN[core] && !dREN[core]) begin
                    busy = 0; rrm = (core + 1) % CPUS;
                end else if (ramstate == ACCESS) begin
                    ew_d[core] = 1'b0;
                    beats++;
                    if (beats == BLOCK_WORDS) begin busy = 0; rrm = (core + 1) % CPUS; end
                end
            end else begin
                if (iREN[core]) begin
                    er = 1'b1; ea = iaddr[core];
                    if (ramstate == ACCESS) begin
                        ew_i[core] = 1'b0; busy = 0; rrm = (core + 1) % CPUS;
                    end
                end else begin
                    busy = 0;
                end
            end
            idone = ~ew_i;
            checks++; if (iwait !== ew_i || dwait !== ew_d) begin errors++; $display("FAIL rnd_wait cyc %0d iwait=%b dwait=%b want %b/%b", n, iwait, dwait, ew_i, ew_d); end
            checks++; if (ramREN !== er || ramWEN !== ew) begin errors++; $display("FAIL rnd_strobe cyc %0d ren=%b wen=%b want %b/%b", n, ramREN, ramWEN, er, ew); end
            checks++; if (ramaddr !== ea || ramstore !== es) begin errors++; $display("FAIL rnd_addr cyc %0d addr=%h st=%h want %h/%h", n, ramaddr, ramstore, ea, es); end
            for (int k = 0; k < CPUS; k++) begin
                checks++; if (iload[k] !== ramload || dload[k] !== ramload) begin errors++; $display("FAIL rnd_load cyc %0d core %0d iload=%h dload=%h want %h", n, k, iload[k], dload[k], ramload); end
            end
        end
        @(negedge CLK);
        clear_inputs();
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_block_read();
        test_priority();
        test_fairness();
        test_busy();
        test_drop();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
